priority_arbiter: RTL and testbench

Registered, parametrised successor to the team's combinational 8-bit priority encoder. It accepts N request lines, grants exactly one requester at a time, and holds that grant until the requester acknowledges, withdraws, or exceeds a hold limit. Typical use: arbitration of shared peripherals or buses between several masters, in place of a bare encoder plus glue logic. Grants are one-hot and also provided as a binary index with a valid flag.

---
 rtl/priority_arbiter.sv | 114 +++++++++++
 tb/tb_priority_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: one-hot grant plus binary index, held until ack, withdrawal or hold limit.
// Define PRIOR_RR_EN for round-robin search order; the default is fixed priority (highest index wins).
module priority_arbiter #(
    parameter int N       = 8,
    parameter int IDXW    = 3,
    parameter int MAXHOLD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld
);

    // state | meaning
    // IDLE  | no grant active, arbitrate whenever any request is present
    // GRANT | gnt/gnt_idx hold the current owner until a release condition
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

    state_t          state, state_nxt;
    logic [7:0]      hold_cnt, hold_cnt_nxt;
    logic [IDXW-1:0] last;
    logic [N-1:0]    gnt_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            vld_nxt;

    logic [N-1:0]    cand;
    logic            expire;
    logic            release_now;
    logic            load;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] scan_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            gnt_vld  <= vld_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

`ifdef PRIOR_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= '0;
        end else if (load) begin
            last <= win_idx;
        end
    end
`else
    assign last = '0;
`endif

    // Search last-1, last-2, ... with wrap; last=0 degenerates to highest-index-first.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            scan_idx = IDXW'((int'(last) + N - i) % N);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        expire      = (MAXHOLD != 0) && (hold_cnt == HOLD_LAST);
        release_now = (state == GRANT) && (ack || !req[gnt_idx] || expire);
        cand        = (state == GRANT) ? (req & ~gnt) : req;
        load        = win_found && ((state == IDLE) || release_now);
        state_nxt   = state;
        case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   if (release_now && !win_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt      = gnt;
        idx_nxt      = gnt_idx;
        vld_nxt      = gnt_vld;
        hold_cnt_nxt = hold_cnt;
        if (load) begin
            gnt_nxt      = N'(1) << win_idx;
            idx_nxt      = win_idx;
            vld_nxt      = 1'b1;
            hold_cnt_nxt = '0;
        end else if (release_now) begin
            gnt_nxt      = '0;
            idx_nxt      = '0;
            vld_nxt      = 1'b0;
            hold_cnt_nxt = '0;
        end else if (state == GRANT && MAXHOLD != 0) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: an unlimited-hold instance and a MAXHOLD=4 instance share stimulus,
// both compared every cycle against a cycle-count reference model.
module tb_priority_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] g0, g1;
    logic [2:0]   i0, i1;
    logic         v0, v1;

    int checks = 0;
    int errors = 0;

    bit m_vld  [2];
    int m_idx  [2];
    int m_held [2];
    int m_last [2];
    int m_max  [2] = '{0, 4};

    always #5 clk = ~clk;

    priority_arbiter #(.N(N), .IDXW(3), .MAXHOLD(0)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .gnt(g0), .gnt_idx(i0), .gnt_vld(v0)
    );

    priority_arbiter #(.N(N), .IDXW(3), .MAXHOLD(4)) dut_h (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .gnt(g1), .gnt_idx(i1), .gnt_vld(v1)
    );

    function automatic int pick(logic [N-1:0] v, int lst);
        for (int k = 1; k <= N; k++) begin
            int c = (lst + N - k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic grant_to(int u, int p);
        m_vld[u]  = 1'b1;
        m_idx[u]  = p;
        m_held[u] = 0;
`ifdef PRIOR_RR_EN
        m_last[u] = p;
`endif
    endtask

    task automatic model_step(int u);
        int p;
        logic [N-1:0] m;
        if (rst) begin
            m_vld[u] = 1'b0; m_idx[u] = 0; m_held[u] = 0; m_last[u] = 0;
        end else if (!m_vld[u]) begin
            p = pick(req, m_last[u]);
            if (p >= 0) grant_to(u, p);
        end else begin
            m_held[u]++;
            if (ack || !req[m_idx[u]] || (m_max[u] != 0 && m_held[u] >= m_max[u])) begin
                m = req;
                m[m_idx[u]] = 1'b0;
                p = pick(m, m_last[u]);
                if (p >= 0) grant_to(u, p);
                else begin m_vld[u] = 1'b0; m_idx[u] = 0; end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick(logic [N-1:0] r_i, logic a_i, logic rs_i);
        logic [N-1:0] eg;
        req = r_i; ack = a_i; rst = rs_i;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        eg = m_vld[0] ? (N'(1) << m_idx[0]) : '0;
        check("gnt",       32'(g0), 32'(eg));
        check("gnt_idx",   32'(i0), 32'(m_vld[0] ? m_idx[0] : 0));
        check("gnt_vld",   32'(v0), 32'(m_vld[0]));
        eg = m_vld[1] ? (N'(1) << m_idx[1]) : '0;
        check("h_gnt",     32'(g1), 32'(eg));
        check("h_gnt_idx", 32'(i1), 32'(m_vld[1] ? m_idx[1] : 0));
        check("h_gnt_vld", 32'(v1), 32'(m_vld[1]));
    endtask

    initial begin
        logic [N-1:0] r;
        logic a, rs;
        rst = 1'b1; req = '0; ack = 1'b0;

        tick(8'hFF, 1'b0, 1'b1);
        tick(8'hFF, 1'b0, 1'b1);
        check("reset_gnt", 32'(g0), 32'h0);
        tick(8'hFF, 1'b0, 1'b0);
        check("first_idx", 32'(i0), 32'd7);

        repeat (5) tick(8'b0101_0001, 1'b0, 1'b0);
        check("prio_idx", 32'(i0), 32'd6);
        tick(8'b0001_0001, 1'b0, 1'b0);
        check("b2b_idx", 32'(i0), 32'd4);
        tick(8'b0001_0001, 1'b1, 1'b0);
        check("ack_idx", 32'(i0), 32'd0);
        tick(8'b0001_0001, 1'b0, 1'b0);
        tick(8'h00, 1'b1, 1'b0);
        tick(8'h00, 1'b1, 1'b0);

        repeat (9) tick(8'hFF, 1'b1, 1'b0);
        repeat (10) tick(8'h01, 1'b0, 1'b0);

        tick(8'h00, 1'b0, 1'b0);
        tick(8'b0101_0001, 1'b0, 1'b0);
        tick(8'b0101_0001, 1'b0, 1'b0);
        tick(8'b0101_0001, 1'b0, 1'b1);
        check("rst_mid_vld", 32'(v0), 32'd0);
        tick(8'b0101_0001, 1'b0, 1'b0);
        check("regrant_idx", 32'(i0), 32'd6);

        r = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) r = N'($urandom);
            if ($urandom_range(0, 7) == 0) r = r & ~g0;
            a  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 99) == 0);
            tick(r, a, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
